pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//   Parametrised, flow-controlled pipeline stage register for inter-stage buffers
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control bundle and a data bundle
//   with a valid/ready handshake, synchronous flush and bubble insertion.
//   Optional one-entry skid register lets in_ready come from state only.
//   One instance replaces each hand-written stage buffer between pipeline stages.
// PARAMETERS
//   CTRL_W       14   width of control bundle (writeBack, regWrt, branch, jump, aluOp, mem, aluSrc)
//   DATA_W       128  width of data bundle (pc_plus_y, xrs, xrt, y = 4 x 32)
//   SKID         1    1: two entries (main + skid); 0: single main register
//   BUBBLE_CTRL  0    value driven on out_ctrl when out_valid=0 (must be a no-op encoding)
// PORTS
//   clock      in   1       rising-edge clock
//   reset      in   1       asynchronous, active-high reset
//   flush      in   1       synchronous squash of all held entries (branch/jump taken)
//   in_valid   in   1       upstream stage presents a valid entry
//   in_ready   out  1       this stage accepts an entry this cycle
//   in_ctrl    in   CTRL_W  upstream control bundle
//   in_data    in   DATA_W  upstream data bundle
//   out_valid  out  1       main register holds a valid entry
//   out_ready  in   1       downstream consumes out_* this cycle (0 = stall)
//   out_ctrl   out  CTRL_W  held control, forced to BUBBLE_CTRL when !out_valid
//   out_data   out  DATA_W  held data (value unspecified-but-stable when !out_valid)
//   occupancy  out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//   - accept = in_valid & in_ready; drain = out_valid & out_ready.
//   - Reset (async): state EMPTY, main/skid regs 0, out_valid 0, occupancy 0,
//     out_ctrl BUBBLE_CTRL, out_data 0, in_ready 1. Mid-operation reset drops all entries.
//   - Latency: entry accepted on edge N appears on out_* after edge N (1 cycle).
//   - States (SKID=1): EMPTY (occ 0), ONE (occ 1), TWO (occ 2).
//     EMPTY: accept -> ONE, main<=in.
//     ONE:   accept&drain -> ONE, main<=in; accept&!drain -> TWO, skid<=in;
//            !accept&drain -> EMPTY; else hold.
//     TWO:   drain -> ONE, main<=skid; else hold. Order preserved (main before skid).
//   - in_ready (SKID=1) = (state != TWO); registered-state only, no path from out_ready.
//   - SKID=0: states EMPTY/ONE only; in_ready = !out_valid | out_ready (combinational);
//     ONE with accept&drain -> ONE, main<=in.
//   - flush has priority over every transfer: next state EMPTY, both entries dropped,
//     in-flight input that cycle discarded even if in_valid=1; out_valid=0 next cycle.
//   - flush & reset: reset wins. flush in EMPTY: no effect.
//   - Stall (out_ready=0): main and skid hold bit-exact; no entry lost or duplicated.
//   - out_ctrl = out_valid ? main_ctrl : BUBBLE_CTRL, so downstream never sees a
//     stale regWrt/memWrite when empty. out_data not gated.
//   - No arithmetic; occupancy equals state encoding.
// STRUCTURE
//   - Shared package: state encodings (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2),
//     default CTRL_W/DATA_W per pipeline boundary, BUBBLE_CTRL constant.
//   - Single module, no sub-modules; skid register in a generate block on SKID.
// TESTING
//   1 Reset: assert reset mid-stream with occ=2 -> out_valid=0, occupancy=0,
//     out_ctrl=BUBBLE_CTRL, in_ready=1 immediately, without a clock edge.
//   2 Streaming: in_valid=1, out_ready=1, data 1..8 -> out_data 1..8 one cycle
//     later, occupancy stays 1, in_ready stays 1.
//   3 Stall: send A,B,C with out_ready=0 -> occ 1 then 2, in_ready=0 after B,
//     C held upstream; release -> outputs A,B,C in order, no duplicates.
//   4 Flush: occ=2 (A,B) with in_valid=1 (C) and flush=1 -> next cycle out_valid=0,
//     occupancy 0, out_ctrl=BUBBLE_CTRL; A, B, C never appear.
//   5 SKID=0: out_ready=0 with valid held -> in_ready=0 same cycle; out_ready=1 with
//     in_valid=1 -> replacement in one cycle, occupancy never exceeds 1.
//   6 Random valid/ready/flush, 10k cycles, scoreboard vs reference queue -> order
//     exact, zero loss/duplication between flushes, in_ready never depends on out_ready (SKID=1).

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipeline stage buffers: state encoding, per-boundary
// bundle widths and the no-op control encoding driven while a stage is empty.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Bundle widths at each pipeline boundary (data is 32-bit words).
    localparam int unsigned IF_ID_CTRL_W  = 1;
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned ID_EX_CTRL_W  = 14;
    localparam int unsigned ID_EX_DATA_W  = 128;
    localparam int unsigned EX_MEM_CTRL_W = 8;
    localparam int unsigned EX_MEM_DATA_W = 96;
    localparam int unsigned MEM_WB_CTRL_W = 3;
    localparam int unsigned MEM_WB_DATA_W = 64;

    localparam int unsigned CTRL_W_DEFAULT = ID_EX_CTRL_W;
    localparam int unsigned DATA_W_DEFAULT = ID_EX_DATA_W;

    // All-zero control: no regWrt, no memWrite, no branch/jump.
    localparam logic [CTRL_W_DEFAULT-1:0] BUBBLE_NOP = '0;

endpackage

// File: rtl/pipe_stage_buf.sv
// Flow-controlled pipeline stage register with flush, bubble insertion on empty and an
// optional skid entry so that in_ready is a function of registered state only.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned       CTRL_W      = CTRL_W_DEFAULT,
    parameter int unsigned       DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned       SKID        = 1,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_NOP)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_e            state_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              accept;
    logic              drain;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign occupancy = state_q;

    // Downstream must never see a stale regWrt/memWrite while the stage is empty.
    assign out_ctrl  = out_valid ? main_ctrl_q : BUBBLE_CTRL;
    assign out_data  = main_data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q     <= ST_ONE;
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ctrl_q <= in_ctrl;
                        main_data_q <= in_data;
                    end else if (accept && (SKID != 0)) begin
                        state_q <= ST_TWO;
                    end else if (drain) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_q     <= ST_ONE;
                        main_ctrl_q <= skid_ctrl_q;
                        main_data_q <= skid_data_q;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Registered-state ready: the skid entry absorbs the one in-flight word.
            assign in_ready = (state_q != ST_TWO);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else if (!flush && (state_q == ST_ONE) && accept && !drain) begin
                    skid_ctrl_q <= in_ctrl;
                    skid_data_q <= in_data;
                end
            end
        end else begin : g_no_skid
            assign in_ready    = !out_valid | out_ready;
            assign skid_ctrl_q = '0;
            assign skid_data_q = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed table, hand-written corner sequences and a randomized scoreboard run for
// pipe_stage_buf with and without the skid entry.
module tb_pipe_stage_buf;
    import pipe_stage_buf_pkg::*;

    localparam int unsigned CW = 14;
    localparam int unsigned DW = 128;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush, in_valid, out_ready, in_ready, out_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    logic          flush0, in_valid0, out_ready0, in_ready0, out_valid0;
    logic [CW-1:0] in_ctrl0, out_ctrl0;
    logic [DW-1:0] in_data0, out_data0;
    logic [1:0]    occupancy0;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .BUBBLE_CTRL(BUBBLE_NOP)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .occupancy(occupancy)
    );

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .BUBBLE_CTRL(BUBBLE_NOP)) dut0 (
        .clock(clock), .reset(reset), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occupancy0)
    );

    function automatic logic [DW-1:0] mk_data(int unsigned k);
        return {32'hA500_0000 + k + 3, 32'h5A00_0000 + k + 2, 32'h3C00_0000 + k + 1, k};
    endfunction

    function automatic logic [CW-1:0] mk_ctrl(int unsigned k);
        return CW'(k) | 14'h2000;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic f, input logic v, input logic r, input int unsigned k);
        flush     = f;
        in_valid  = v;
        out_ready = r;
        in_ctrl   = mk_ctrl(k);
        in_data   = mk_data(k);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct packed {
        logic       flush;
        logic       iv;
        logic       ordy;
        logic [7:0] k;
        logic       ev;
        logic [1:0] eocc;
        logic       eir;
        logic [7:0] ek;
    } vec_t;

    vec_t vecs [17];

    int unsigned q [$];
    int          rnd_err;
    int          drains;
    int unsigned next_k;
    logic        ir_before, acc, drn;

    initial begin
        // flush iv ordy k | ev occ ir ek
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd1,  1'b1, 2'd1, 1'b1, 8'd1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd2,  1'b1, 2'd2, 1'b0, 8'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd3,  1'b1, 2'd2, 1'b0, 8'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'd3,  1'b1, 2'd1, 1'b1, 8'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd3,  1'b1, 2'd2, 1'b0, 8'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 2'd1, 1'b1, 8'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 2'd0, 1'b1, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'd4,  1'b1, 2'd1, 1'b1, 8'd4};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'd5,  1'b1, 2'd1, 1'b1, 8'd5};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd6,  1'b1, 2'd2, 1'b0, 8'd5};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'd7,  1'b0, 2'd0, 1'b1, 8'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 2'd0, 1'b1, 8'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd8,  1'b1, 2'd1, 1'b1, 8'd8};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'd9,  1'b0, 2'd0, 1'b1, 8'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 2'd0, 1'b1, 8'd0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'd10, 1'b1, 2'd1, 1'b1, 8'd10};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 2'd0, 1'b1, 8'd0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 0);
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        in_ctrl0 = '0; in_data0 = '0;
        #1;
        check("rst_out_valid", DW'(out_valid), DW'(1'b0));
        check("rst_out_ctrl", DW'(out_ctrl), DW'(BUBBLE_NOP));
        check("rst_in_ready", DW'(in_ready), DW'(1'b1));
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Table-driven directed vectors on the skid instance.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].flush, vecs[i].iv, vecs[i].ordy, int'(vecs[i].k));
            tick();
            check($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].ev));
            check($sformatf("vec%0d_occupancy", i), DW'(occupancy), DW'(vecs[i].eocc));
            check($sformatf("vec%0d_in_ready", i), DW'(in_ready), DW'(vecs[i].eir));
            check($sformatf("vec%0d_out_ctrl", i), DW'(out_ctrl),
                  DW'(vecs[i].ev ? mk_ctrl(int'(vecs[i].ek)) : BUBBLE_NOP));
            if (vecs[i].ev)
                check($sformatf("vec%0d_out_data", i), out_data, mk_data(int'(vecs[i].ek)));
        end

        // Streaming: one word per cycle, occupancy stays at one.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b1, 1'b1, k);
            tick();
            check($sformatf("stream%0d_data", k), out_data, mk_data(k));
            check($sformatf("stream%0d_occ", k), DW'(occupancy), DW'(2'd1));
            check($sformatf("stream%0d_in_ready", k), DW'(in_ready), DW'(1'b1));
        end
        drive(1'b0, 1'b0, 1'b1, 0);
        tick();
        check("stream_end_valid", DW'(out_valid), DW'(1'b0));

        // Asynchronous reset while holding two entries.
        drive(1'b0, 1'b1, 1'b0, 20);
        tick();
        drive(1'b0, 1'b1, 1'b0, 21);
        tick();
        check("pre_reset_occ", DW'(occupancy), DW'(2'd2));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", DW'(out_valid), DW'(1'b0));
        check("async_rst_occ", DW'(occupancy), DW'(2'd0));
        check("async_rst_ctrl", DW'(out_ctrl), DW'(BUBBLE_NOP));
        check("async_rst_in_ready", DW'(in_ready), DW'(1'b1));
        check("async_rst_data", out_data, '0);
        drive(1'b0, 1'b0, 1'b0, 0);
        #1;
        reset = 1'b0;
        tick();
        check("post_reset_valid", DW'(out_valid), DW'(1'b0));

        // Single-entry variant: ready follows out_ready combinationally.
        in_valid0 = 1'b1; in_ctrl0 = mk_ctrl(30); in_data0 = mk_data(30); out_ready0 = 1'b0;
        tick();
        check("s0_first_valid", DW'(out_valid0), DW'(1'b1));
        in_ctrl0 = mk_ctrl(31); in_data0 = mk_data(31);
        #1;
        check("s0_stall_in_ready", DW'(in_ready0), DW'(1'b0));
        tick();
        check("s0_stall_hold", out_data0, mk_data(30));
        check("s0_stall_occ", DW'(occupancy0), DW'(2'd1));
        out_ready0 = 1'b1;
        #1;
        check("s0_release_in_ready", DW'(in_ready0), DW'(1'b1));
        tick();
        check("s0_replace_data", out_data0, mk_data(31));
        check("s0_replace_occ", DW'(occupancy0), DW'(2'd1));
        check("s0_replace_ctrl", DW'(out_ctrl0), DW'(mk_ctrl(31)));
        in_valid0 = 1'b0;
        tick();
        check("s0_drain_valid", DW'(out_valid0), DW'(1'b0));
        check("s0_drain_ctrl", DW'(out_ctrl0), DW'(BUBBLE_NOP));

        // Randomized traffic against a reference queue.
        rnd_err = 0;
        drains  = 0;
        next_k  = 100;
        for (int c = 0; c < 10000; c++) begin
            if (occupancy !== 2'(q.size())) rnd_err++;
            if (out_valid !== (q.size() > 0)) rnd_err++;
            if (in_ready !== (q.size() < 2)) rnd_err++;
            if (q.size() > 0) begin
                if (out_data !== mk_data(q[0])) rnd_err++;
                if (out_ctrl !== mk_ctrl(q[0])) rnd_err++;
            end else if (out_ctrl !== BUBBLE_NOP) begin
                rnd_err++;
            end
            ir_before = in_ready;
            drive($urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < (((c / 1000) % 2 == 1) ? 80 : 30), next_k);
            #1;
            if (in_ready !== ir_before) rnd_err++;
            acc = in_valid & in_ready;
            drn = out_valid & out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (drn) begin
                    void'(q.pop_front());
                    drains++;
                end
                if (acc) q.push_back(next_k);
            end
            if (acc) next_k++;
            tick();
        end
        check("random_errors", DW'(rnd_err), DW'(0));
        check("random_drained", DW'(drains > 1000), DW'(1'b1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
